// File: rtl/rom_load_router_pkg.sv
// Shared constants for the ROM download path: region table, storage kinds,
// the backend word carried between the router and its issue stage.
package rom_load_router_pkg;

   localparam int LOAD_NUM_REGIONS = 6;
   localparam int REGION_IDX_W     = 3;

   typedef enum logic [1:0] {
      STORE_SDR   = 2'd0,
      STORE_DDR   = 2'd1,
      STORE_BLOCK = 2'd2
   } region_storage_t;

   typedef struct packed {
      logic [31:0]     base_addr;
      region_storage_t storage;
   } region_desc_t;

   // One backend write: kind selects the port, addr is already word aligned.
   typedef struct packed {
      region_storage_t kind;
      logic [31:0]     addr;
      logic [63:0]     data;
      logic [7:0]      be;
   } load_word_t;

   localparam region_desc_t LOAD_REGIONS [LOAD_NUM_REGIONS] = '{
      '{base_addr: 32'h0000_0000, storage: STORE_SDR},
      '{base_addr: 32'h0080_0000, storage: STORE_SDR},
      '{base_addr: 32'h0020_0000, storage: STORE_DDR},
      '{base_addr: 32'h0010_0000, storage: STORE_BLOCK},
      '{base_addr: 32'h0040_0000, storage: STORE_DDR},
      '{base_addr: 32'h0000_8000, storage: STORE_BLOCK}
   };

   function automatic int storage_width_bytes(input region_storage_t kind);
      case (kind)
         STORE_SDR: return 2;
         STORE_DDR: return 8;
         default:   return 1;
      endcase
   endfunction

   // Byte-enable pattern of a word with every lane written.
   function automatic logic [7:0] storage_full_mask(input region_storage_t kind);
      case (storage_width_bytes(kind))
         2:       return 8'h03;
         8:       return 8'hFF;
         default: return 8'h01;
      endcase
   endfunction

endpackage

// File: rtl/rom_load_issue.sv
// Issue stage: holds one completed word and runs the handshake of the
// backend that owns it. The stage is busy for as long as a word is held.
module rom_load_issue
   import rom_load_router_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        issue_load,
   input  load_word_t  issue_word,
   output logic        busy,
   output logic [31:0] sdr_addr,
   output logic [15:0] sdr_data,
   output logic [1:0]  sdr_be,
   output logic        sdr_req,
   input  logic        sdr_ack,
   output logic [31:0] ddr_addr,
   output logic [63:0] ddr_data,
   output logic [7:0]  ddr_be,
   output logic        ddr_wr,
   input  logic        ddr_busy,
   output logic [31:0] blk_addr,
   output logic [7:0]  blk_data,
   output logic        blk_we
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SDR  = 2'd1,
      S_DDR  = 2'd2,
      S_BLK  = 2'd3
   } issue_state_t;

   issue_state_t state_reg, state_next;
   logic [31:0]  addr_reg;
   logic [63:0]  data_reg;
   logic [7:0]   be_reg;

   // State and issue register; the word is captured only when the stage is free.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
         addr_reg  <= '0;
         data_reg  <= '0;
         be_reg    <= '0;
      end else begin
         state_reg <= state_next;
         if (issue_load && state_reg == S_IDLE) begin
            addr_reg <= issue_word.addr;
            data_reg <= issue_word.data;
            be_reg   <= issue_word.be;
         end
      end
   end

   // Next state and strobes; strobes decode from the state so reset kills them at once.
   always_comb begin
      state_next = state_reg;
      sdr_req    = 1'b0;
      ddr_wr     = 1'b0;
      blk_we     = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (issue_load) begin
               case (issue_word.kind)
                  STORE_SDR: state_next = S_SDR;
                  STORE_DDR: state_next = S_DDR;
                  default:   state_next = S_BLK;
               endcase
            end
         end
         S_SDR: begin
            sdr_req = 1'b1;
            if (sdr_ack) state_next = S_IDLE;
         end
         S_DDR: begin
            ddr_wr = 1'b1;
            if (!ddr_busy) state_next = S_IDLE;
         end
         S_BLK: begin
            blk_we     = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign busy     = (state_reg != S_IDLE);
   assign sdr_addr = addr_reg;
   assign sdr_data = data_reg[15:0];
   assign sdr_be   = be_reg[1:0];
   assign ddr_addr = addr_reg;
   assign ddr_data = data_reg;
   assign ddr_be   = be_reg;
   assign blk_addr = addr_reg;
   assign blk_data = data_reg[7:0];

endmodule

// File: rtl/rom_load_router.sv
// ROM download router: translates region offsets to absolute addresses,
// packs bytes into backend words in an accumulator and hands full (or
// flushed) words to the issue stage.
module rom_load_router
   import rom_load_router_pkg::*;
#(
   parameter int           NUM_REGIONS = LOAD_NUM_REGIONS,
   parameter region_desc_t REGIONS [NUM_REGIONS] = LOAD_REGIONS
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load_wr,
   input  logic [REGION_IDX_W-1:0] load_region,
   input  logic [26:0]             load_offset,
   input  logic [7:0]              load_data,
   input  logic                    load_flush,
   output logic                    load_busy,
   output logic                    load_err,
   output logic [31:0]             sdr_addr,
   output logic [15:0]             sdr_data,
   output logic [1:0]              sdr_be,
   output logic                    sdr_req,
   input  logic                    sdr_ack,
   output logic [31:0]             ddr_addr,
   output logic [63:0]             ddr_data,
   output logic [7:0]              ddr_be,
   output logic                    ddr_wr,
   input  logic                    ddr_busy,
   output logic [31:0]             blk_addr,
   output logic [7:0]              blk_data,
   output logic                    blk_we
);

   region_desc_t    sel_desc;
   logic            in_range;
   logic [31:0]     abs_addr;
   region_storage_t in_kind;
   logic [31:0]     in_waddr;
   logic [2:0]      in_lane;

   logic            acc_valid_reg, acc_valid_next;
   load_word_t      acc_word_reg, acc_word_next;
   logic            err_reg;

   logic            wr_acc, fl_acc, byte_ok;
   logic            acc_complete, mismatch, handoff;
   logic [63:0]     base_data, merged_data;
   logic [7:0]      base_be, merged_be, lane_hit;
   load_word_t      merged_word;
   logic            merged_complete;
   logic            issue_load;
   load_word_t      issue_word;

   // Region lookup by compare so out-of-range indices never address the table.
   always_comb begin
      sel_desc = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         if (load_region == REGION_IDX_W'(i)) sel_desc = REGIONS[i];
      end
   end

   assign in_range = ({29'd0, load_region} < 32'(NUM_REGIONS));
   assign abs_addr = sel_desc.base_addr + {5'd0, load_offset};
   assign in_kind  = sel_desc.storage;

   // Word address and byte lane from the backend width of the target region.
   always_comb begin
      in_waddr = abs_addr;
      in_lane  = 3'd0;
      case (in_kind)
         STORE_SDR: begin
            in_waddr = {abs_addr[31:1], 1'b0};
            in_lane  = {2'b00, abs_addr[0]};
         end
         STORE_DDR: begin
            in_waddr = {abs_addr[31:3], 3'b000};
            in_lane  = abs_addr[2:0];
         end
         default: begin
            in_waddr = abs_addr;
            in_lane  = 3'd0;
         end
      endcase
   end

   assign wr_acc  = load_wr & ~load_busy;
   assign fl_acc  = load_flush & ~load_busy;
   assign byte_ok = wr_acc & in_range;

   // A complete word only lingers in the accumulator when it was started while
   // the issue slot was taken by a hand-off; it drains at the next free cycle.
   assign acc_complete = acc_valid_reg &&
                         (acc_word_reg.be == storage_full_mask(acc_word_reg.kind));
   assign mismatch     = acc_valid_reg &&
                         ((acc_word_reg.kind != in_kind) || (acc_word_reg.addr != in_waddr));
   assign handoff      = mismatch || acc_complete;

   // Merge base: the current accumulator when the byte continues it, else an empty word.
   always_comb begin
      base_data = '0;
      base_be   = '0;
      if (acc_valid_reg && !handoff) begin
         base_data = acc_word_reg.data;
         base_be   = acc_word_reg.be;
      end
   end

   for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign lane_hit[gi]             = (in_lane == 3'(gi));
      assign merged_data[8*gi +: 8]   = lane_hit[gi] ? load_data : base_data[8*gi +: 8];
      assign merged_be[gi]            = lane_hit[gi] | base_be[gi];
   end

   assign merged_word.kind = in_kind;
   assign merged_word.addr = in_waddr;
   assign merged_word.data = merged_data;
   assign merged_word.be   = merged_be;
   assign merged_complete  = (merged_be == storage_full_mask(in_kind));

   // Accumulator update and issue decision for one accepted byte and/or flush.
   always_comb begin
      acc_valid_next = acc_valid_reg;
      acc_word_next  = acc_word_reg;
      issue_load     = 1'b0;
      issue_word     = acc_word_reg;
      if (byte_ok) begin
         if (handoff) begin
            // Old word takes the only issue slot; the new byte waits, even if flushed.
            issue_load     = 1'b1;
            issue_word     = acc_word_reg;
            acc_valid_next = 1'b1;
            acc_word_next  = merged_word;
         end else if (merged_complete || fl_acc) begin
            issue_load     = 1'b1;
            issue_word     = merged_word;
            acc_valid_next = 1'b0;
            acc_word_next  = '0;
         end else begin
            acc_valid_next = 1'b1;
            acc_word_next  = merged_word;
         end
      end else if (!load_busy && acc_valid_reg && (fl_acc || acc_complete)) begin
         issue_load     = 1'b1;
         issue_word     = acc_word_reg;
         acc_valid_next = 1'b0;
         acc_word_next  = '0;
      end
   end

   // Accumulator register and sticky region error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_valid_reg <= 1'b0;
         acc_word_reg  <= '0;
         err_reg       <= 1'b0;
      end else begin
         acc_valid_reg <= acc_valid_next;
         acc_word_reg  <= acc_word_next;
         if (wr_acc && !in_range) err_reg <= 1'b1;
      end
   end

   assign load_err = err_reg;

   rom_load_issue u_issue (
      .clk        (clk),
      .reset      (reset),
      .issue_load (issue_load),
      .issue_word (issue_word),
      .busy       (load_busy),
      .sdr_addr   (sdr_addr),
      .sdr_data   (sdr_data),
      .sdr_be     (sdr_be),
      .sdr_req    (sdr_req),
      .sdr_ack    (sdr_ack),
      .ddr_addr   (ddr_addr),
      .ddr_data   (ddr_data),
      .ddr_be     (ddr_be),
      .ddr_wr     (ddr_wr),
      .ddr_busy   (ddr_busy),
      .blk_addr   (blk_addr),
      .blk_data   (blk_data),
      .blk_we     (blk_we)
   );

endmodule

// File: tb/tb_rom_load_router.sv
// Directed bench for rom_load_router: SDR pair, DDR burst, block byte,
// discontinuity with flush, region switch, duplicate lane, error and reset.
module tb_rom_load_router;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_wr;
   logic [2:0]  load_region;
   logic [26:0] load_offset;
   logic [7:0]  load_data;
   logic        load_flush;
   logic        load_busy;
   logic        load_err;
   logic [31:0] sdr_addr;
   logic [15:0] sdr_data;
   logic [1:0]  sdr_be;
   logic        sdr_req;
   logic        sdr_ack;
   logic [31:0] ddr_addr;
   logic [63:0] ddr_data;
   logic [7:0]  ddr_be;
   logic        ddr_wr;
   logic        ddr_busy;
   logic [31:0] blk_addr;
   logic [7:0]  blk_data;
   logic        blk_we;

   int total = 0;
   int bad   = 0;
   int sdr_done = 0, ddr_done = 0, ddr_wr_cycles = 0, blk_pulses = 0;

   always #5 clk = ~clk;

   rom_load_router dut (
      .clk         (clk),
      .reset       (reset),
      .load_wr     (load_wr),
      .load_region (load_region),
      .load_offset (load_offset),
      .load_data   (load_data),
      .load_flush  (load_flush),
      .load_busy   (load_busy),
      .load_err    (load_err),
      .sdr_addr    (sdr_addr),
      .sdr_data    (sdr_data),
      .sdr_be      (sdr_be),
      .sdr_req     (sdr_req),
      .sdr_ack     (sdr_ack),
      .ddr_addr    (ddr_addr),
      .ddr_data    (ddr_data),
      .ddr_be      (ddr_be),
      .ddr_wr      (ddr_wr),
      .ddr_busy    (ddr_busy),
      .blk_addr    (blk_addr),
      .blk_data    (blk_data),
      .blk_we      (blk_we)
   );

   // Backend activity counters sampled on the active edge.
   always @(posedge clk) begin
      if (sdr_req && sdr_ack)  sdr_done      <= sdr_done + 1;
      if (ddr_wr && !ddr_busy) ddr_done      <= ddr_done + 1;
      if (ddr_wr)              ddr_wr_cycles <= ddr_wr_cycles + 1;
      if (blk_we)              blk_pulses    <= blk_pulses + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] r, input logic [26:0] off, input logic [7:0] d);
      load_wr     = 1'b1;
      load_region = r;
      load_offset = off;
      load_data   = d;
      step();
      load_wr     = 1'b0;
   endtask

   task automatic ack_sdr();
      sdr_ack = 1'b1;
      step();
      sdr_ack = 1'b0;
   endtask

   initial begin
      reset = 1'b1; load_wr = 1'b0; load_region = '0; load_offset = '0;
      load_data = '0; load_flush = 1'b0; sdr_ack = 1'b0; ddr_busy = 1'b0;
      repeat (2) step();
      check("rst_sdr_req", sdr_req, 0);
      check("rst_ddr_wr", ddr_wr, 0);
      check("rst_blk_we", blk_we, 0);
      check("rst_busy", load_busy, 0);
      check("rst_err", load_err, 0);
      check("rst_sdr_addr", sdr_addr, 0);
      check("rst_ddr_data", ddr_data, 0);
      reset = 1'b0;
      step();

      // SDR lane pair
      send(3'd0, 27'h10, 8'hAA);
      check("sdr1_busy_after_first", load_busy, 0);
      check("sdr1_req_after_first", sdr_req, 0);
      send(3'd0, 27'h11, 8'hBB);
      check("sdr1_req", sdr_req, 1);
      check("sdr1_addr", sdr_addr, 32'h0000_0010);
      check("sdr1_data", sdr_data, 16'hBBAA);
      check("sdr1_be", sdr_be, 2'b11);
      check("sdr1_busy", load_busy, 1);
      step();
      step();
      check("sdr1_req_held", sdr_req, 1);
      check("sdr1_busy_held", load_busy, 1);
      ack_sdr();
      check("sdr1_req_drop", sdr_req, 0);
      check("sdr1_busy_drop", load_busy, 0);
      check("sdr1_count", sdr_done, 1);

      // DDR burst with waitrequest for 3 cycles
      ddr_busy = 1'b1;
      for (int i = 0; i < 8; i++) send(3'd2, 27'(i), 8'(i));
      check("ddr_wr", ddr_wr, 1);
      check("ddr_addr", ddr_addr, 32'h0020_0000);
      check("ddr_data", ddr_data, 64'h0706_0504_0302_0100);
      check("ddr_be", ddr_be, 8'hFF);
      check("ddr_busy_out", load_busy, 1);
      repeat (3) step();
      check("ddr_wr_held", ddr_wr, 1);
      check("ddr_data_held", ddr_data, 64'h0706_0504_0302_0100);
      ddr_busy = 1'b0;
      step();
      check("ddr_wr_drop", ddr_wr, 0);
      check("ddr_count", ddr_done, 1);
      check("ddr_wr_cycles", ddr_wr_cycles, 4);

      // Block byte
      send(3'd3, 27'd5, 8'h5A);
      check("blk_we", blk_we, 1);
      check("blk_addr", blk_addr, 32'h0010_0005);
      check("blk_data", blk_data, 8'h5A);
      check("blk_busy", load_busy, 1);
      step();
      check("blk_we_drop", blk_we, 0);
      check("blk_busy_drop", load_busy, 0);
      check("blk_count", blk_pulses, 1);

      // Discontinuity then flush
      send(3'd0, 27'd0, 8'h11);
      send(3'd0, 27'd4, 8'h22);
      check("disc1_req", sdr_req, 1);
      check("disc1_addr", sdr_addr, 32'h0);
      check("disc1_data", sdr_data, 16'h0011);
      check("disc1_be", sdr_be, 2'b01);
      load_flush = 1'b1;
      ack_sdr();
      check("disc_gap_req", sdr_req, 0);
      check("disc_gap_busy", load_busy, 0);
      step();
      load_flush = 1'b0;
      check("disc2_req", sdr_req, 1);
      check("disc2_addr", sdr_addr, 32'h4);
      check("disc2_data", sdr_data, 16'h0022);
      check("disc2_be", sdr_be, 2'b01);
      ack_sdr();
      check("disc_count", sdr_done, 3);

      // Region switch SDR -> DDR
      send(3'd0, 27'd0, 8'hAA);
      send(3'd2, 27'd0, 8'hBB);
      check("sw_req", sdr_req, 1);
      check("sw_sdr_data", sdr_data, 16'h00AA);
      check("sw_sdr_be", sdr_be, 2'b01);
      ack_sdr();
      check("sw_ddr_idle", ddr_wr, 0);
      load_flush = 1'b1;
      step();
      load_flush = 1'b0;
      check("sw_ddr_wr", ddr_wr, 1);
      check("sw_ddr_addr", ddr_addr, 32'h0020_0000);
      check("sw_ddr_data", ddr_data, 64'hBB);
      check("sw_ddr_be", ddr_be, 8'h01);
      step();
      check("sw_ddr_drop", ddr_wr, 0);
      check("sw_ddr_count", ddr_done, 2);
      check("sw_ddr_cycles", ddr_wr_cycles, 5);

      // Duplicate lane overwrite
      send(3'd0, 27'h30, 8'h01);
      send(3'd0, 27'h30, 8'h02);
      check("dup_no_req", sdr_req, 0);
      send(3'd0, 27'h31, 8'h03);
      check("dup_addr", sdr_addr, 32'h30);
      check("dup_data", sdr_data, 16'h0302);
      check("dup_be", sdr_be, 2'b11);
      ack_sdr();

      // Out-of-range regions
      send(3'd6, 27'd0, 8'hEE);
      check("err_set", load_err, 1);
      check("err_busy", load_busy, 0);
      send(3'd7, 27'd0, 8'hEF);
      check("err_sticky", load_err, 1);
      load_flush = 1'b1;
      step();
      load_flush = 1'b0;
      check("err_no_sdr", sdr_req, 0);
      check("err_no_ddr", ddr_wr, 0);
      check("err_no_blk", blk_we, 0);
      check("err_blk_count", blk_pulses, 1);

      // Asynchronous reset during an SDR request
      send(3'd0, 27'h20, 8'h01);
      send(3'd0, 27'h21, 8'h02);
      check("ar_req_before", sdr_req, 1);
      #2;
      reset = 1'b1;
      #1;
      check("ar_req", sdr_req, 0);
      check("ar_err", load_err, 0);
      check("ar_busy", load_busy, 0);
      check("ar_addr", sdr_addr, 0);
      step();
      reset = 1'b0;
      step();
      check("ar_req_after", sdr_req, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rom_load_router.md
# rom_load_router

Routes the byte-serial ROM download stream to the storage backend that owns each load region: SDRAM, DDR or block RAM. It sits between the download/ioctl front end and the SDR, DDR and block-RAM write ports. It translates region-relative byte offsets into absolute addresses using the shared region table. It packs bytes into backend-width words with byte enables and sequences each backend's write handshake.

## Interface
- NUM_REGIONS, 6: number of valid load regions.
- REGIONS, LOAD_REGIONS: region descriptor array (base address, storage kind), from the shared constants package.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- load_wr  in  1  byte strobe; accepted when load_busy is low.
- load_region  in  3  region index of the byte.
- load_offset  in  27  byte offset within the region.
- load_data  in  8  byte value.
- load_flush  in  1  flush a partial word; accepted under the same rule as load_wr.
- load_busy  out  1  stall: no byte or flush is accepted.
- load_err  out  1  sticky: a byte arrived with an index ≥ NUM_REGIONS.
- sdr_addr  out  32  SDR word address (bit 0 = 0).
- sdr_data  out  16  SDR write data.
- sdr_be  out  2  SDR byte enables.
- sdr_req  out  1  SDR request; held until sdr_ack.
- sdr_ack  in  1  SDR completion pulse.
- ddr_addr  out  32  DDR address (bits 2:0 = 0).
- ddr_data  out  64  DDR write data.
- ddr_be  out  8  DDR byte enables.
- ddr_wr  out  1  DDR write, Avalon style.
- ddr_busy  in  1  DDR waitrequest.
- blk_addr  out  32  block RAM byte address.
- blk_data  out  8  block RAM data.
- blk_we  out  1  block RAM write pulse.

## Operation
- Absolute address: abs = REGIONS[load_region].base_addr + load_offset, computed at 32 bits with wrap.
- Word width by storage kind:
  - SDR: 2 bytes; lane = abs[0].
  - DDR: 8 bytes; lane = abs[2:0].
  - BLOCK: 1 byte.
  - Lanes are little-endian: lane k occupies bits 8k+7:8k.
- Two-entry buffer:
  - Accumulator: valid, storage kind, word address, data, byte mask.
  - Issue register: same fields.
- load_busy = issue register valid.
- Byte accept (load_wr & !load_busy):
  - Out-of-range region: the byte is dropped, load_err is set, and the buffers are unchanged.
  - Accumulator valid with a different kind or word address: the accumulator moves to the issue register and the new byte starts a fresh accumulator.
  - Otherwise: the byte merges into its lane and sets its mask bit. A duplicate lane overwrites the data.
  - When the merged mask is complete, the word moves to the issue register in the same cycle and the accumulator clears. BLOCK bytes always complete.
- Flush accept (load_flush & !load_busy):
  - If the accumulator is valid, it moves to the issue register.
  - A simultaneous load_wr merges its byte first; the resulting word is then flushed.
  - A discontinuity hand-off combined with a flush in the same cycle cannot empty both entries, because only one issue slot exists. The new byte stays in the accumulator and the flush applies to it at the next non-busy accept. The source must hold load_flush until load_busy is low.
- Unwritten lanes: data 0, enable 0.
- Issue FSM states and transitions:
  - IDLE → SDR, DDR or BLK on issue load.
  - SDR: sdr_req held high; exit to IDLE on the cycle sdr_ack is sampled high.
  - DDR: ddr_wr held high; exit to IDLE on the cycle ddr_wr=1 and ddr_busy=0 is sampled.
  - BLK: blk_we high for exactly one cycle, then IDLE.
  - Address, data and byte enables are stable throughout SDR and DDR.
- load_err clears only on reset.

## Timing
- Reset values: all outputs 0; FSM in IDLE; both buffers invalid.
- Reset mid-transaction drops req/wr/we immediately, asynchronously.
- A word completing on edge N drives its backend strobe from cycle N+1.
- BLK path: byte accepted at edge N, blk_we high in cycle N+1, load_busy low again from N+2.
- SDR path: load_busy falls in the cycle after ack is sampled; the next issue can start from the following edge.
- Max throughput is one issue per two cycles; bytes merging into the accumulator while IDLE cost no stall.

## Structure
- Shared package additions:
  - storage_width_bytes(region_storage_t) function.
  - load_word_t packed struct (kind, addr, data[63:0], be[7:0]).
  - Region index width constant.
- Sub-module rom_load_issue: issue register plus FSM driving the three backend handshakes. The top level holds address translation, the accumulator and the error flag.

## Test plan
- SDR lane pair: region 0, offset 0x10, bytes AA then BB, sdr_ack returned 3 cycles after req rises → single sdr_req, addr 0x0000_0010, data 0xBBAA, be 2'b11; load_busy stays high until the cycle after the ack.
- DDR burst: region 2 (VERILATOR base 0x0020_0000), offsets 0–7, bytes 00..07, ddr_busy held for 3 cycles → one write, addr 0x0020_0000, data 0x0706050403020100, be 0xFF, ddr_wr high for 4 cycles.
- Block: region 3, offset 5, byte 5A → blk_addr 0x0010_0005, blk_data 5A, blk_we high for exactly one cycle.
- Discontinuity and flush: region 0 offset 0 byte 11, then offset 4 byte 22, then flush → SDR writes (0x0, 0x0011, be 01) then (0x4, 0x0022, be 01).
- Error and reset: byte with region 7 → load_err=1, no backend strobe. Reset asserted while sdr_req is high → sdr_req=0 and load_err=0 at once.
- Region switch: region 0 offset 0 byte AA, then region 2 offset 0 byte BB → SDR partial (0x0, 0x00AA, be 01) issued; DDR accumulator holds BB until flushed.
